// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
//   Bit-serial magnitude comparator. Operands are captured on an accepted
//   start and scanned MSB-first, one bit per clock, stopping at the first
//   differing bit. Supports unsigned and two's-complement comparison.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        request, sampled only while idle
//   a, b         WIDTH-bit operands, captured at accepted start
//   signed_mode  1 = two's-complement compare, captured at accepted start
//   busy         high while scanning and in the done cycle
//   done         one-cycle pulse, result flags valid
//   less         A < B
//   great        A > B
//   equal        A == B
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             less,
  output logic             great,
  output logic             equal
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic             r_signed;
  logic             w_signed_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             r_less;
  logic             r_great;
  logic             r_equal;
  logic             w_less_nxt;
  logic             w_great_nxt;
  logic             w_equal_nxt;

  // The operands shift left, so the bit under test is always the MSB.
  logic w_ai;
  logic w_bi;
  logic w_sign_pos;

  assign w_ai       = r_a[WIDTH-1];
  assign w_bi       = r_b[WIDTH-1];
  assign w_sign_pos = (r_idx == IDX_MSB);

  // ---- next-state / datapath decision ----
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_signed_nxt = r_signed;
    w_idx_nxt    = r_idx;
    w_less_nxt   = r_less;
    w_great_nxt  = r_great;
    w_equal_nxt  = r_equal;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a_nxt      = a;
          w_b_nxt      = b;
          w_signed_nxt = signed_mode;
          w_idx_nxt    = IDX_MSB;
          w_less_nxt   = 1'b0;
          w_great_nxt  = 1'b0;
          w_equal_nxt  = 1'b0;
          w_state_nxt  = S_SCAN;
        end
      end

      S_SCAN: begin
        if (w_ai != w_bi) begin
          // In two's complement a set sign bit means the smaller value.
          if (r_signed && w_sign_pos) begin
            w_great_nxt = ~w_ai & w_bi;
            w_less_nxt  = w_ai & ~w_bi;
          end else begin
            w_great_nxt = w_ai & ~w_bi;
            w_less_nxt  = ~w_ai & w_bi;
          end
          w_state_nxt = S_DONE;
        end else if (r_idx != '0) begin
          w_idx_nxt = r_idx - 1'b1;
          w_a_nxt   = {r_a[WIDTH-2:0], 1'b0};
          w_b_nxt   = {r_b[WIDTH-2:0], 1'b0};
        end else begin
          w_equal_nxt = 1'b1;
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= '0;
      r_less   <= 1'b0;
      r_great  <= 1'b0;
      r_equal  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_signed <= w_signed_nxt;
      r_idx    <= w_idx_nxt;
      r_less   <= w_less_nxt;
      r_great  <= w_great_nxt;
      r_equal  <= w_equal_nxt;
    end
  end

  // Outputs decode registered state only; no input-to-output path.
  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign less  = r_less;
  assign great = r_great;
  assign equal = r_equal;

endmodule
